// File: rtl/line_window_sequencer.sv
// Raster sequencer for the multitap line buffer: loads tap spacing, gates pixels,
// tracks x/y and flags cycles where taps + live pixel form a full vertical column.
module line_window_sequencer #(
  parameter int COORD_BITS      = 8,
  parameter int NUM_TAPS        = 3,
  parameter int MAX_TAP_SPACING = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cfg_valid,
  input  logic [COORD_BITS-1:0] cfg_width,
  input  logic [COORD_BITS-1:0] cfg_height,
  output logic                  cfg_ready,
  output logic                  cfg_error,
  input  logic                  abort,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  sr_reset,
  output logic [15:0]           sr_tap_spacing,
  output logic                  sr_in_valid,
  output logic                  win_valid,
  output logic [COORD_BITS-1:0] win_x,
  output logic [COORD_BITS-1:0] win_y,
  output logic                  frame_done
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam logic [COORD_BITS-1:0] MAX_W  = COORD_BITS'(MAX_TAP_SPACING);
  localparam logic [COORD_BITS-1:0] MIN_H  = COORD_BITS'(NUM_TAPS + 1);
  localparam logic [COORD_BITS-1:0] TAPS_C = COORD_BITS'(NUM_TAPS);
  localparam logic [COORD_BITS-1:0] ONE    = COORD_BITS'(1);

  state_t                state, state_nxt;
  logic [COORD_BITS-1:0] x, y, width_reg, height_reg;
  logic                  cfg_legal, cfg_take, accept, last_col, last_px;

  assign cfg_legal = (cfg_width != '0) && (cfg_width <= MAX_W) && (cfg_height >= MIN_H);
  assign cfg_take  = (state == IDLE) && cfg_valid;
  assign accept    = in_valid && in_ready;
  assign last_col  = (x == width_reg - ONE);
  assign last_px   = last_col && (y == height_reg - ONE);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (cfg_take && cfg_legal) state_nxt = LOAD;
      LOAD: state_nxt = abort ? IDLE : RUN;
      // abort wins over a simultaneous last pixel: the frame is dropped
      RUN:  if (abort)                 state_nxt = IDLE;
            else if (accept && last_px) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready  = 1'b0;
    in_ready   = 1'b0;
    sr_reset   = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: cfg_ready  = reset_n;
      LOAD: sr_reset   = 1'b1;
      RUN:  in_ready   = 1'b1;
      DONE: frame_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      x          <= '0;
      y          <= '0;
      width_reg  <= '0;
      height_reg <= '0;
      cfg_error  <= 1'b0;
    end else begin
      cfg_error <= cfg_take && !cfg_legal;
      if (cfg_take && cfg_legal) begin
        width_reg  <= cfg_width;
        height_reg <= cfg_height;
        x          <= '0;
        y          <= '0;
      end else if (accept) begin
        if (last_col) begin
          x <= '0;
          y <= y + ONE;
        end else begin
          x <= x + ONE;
        end
      end
    end
  end

  assign sr_tap_spacing = 16'(width_reg);
  assign sr_in_valid    = accept;
  assign win_valid      = accept && (y >= TAPS_C);
  assign win_x          = x;
  assign win_y          = y - TAPS_C;

endmodule

// File: tb/tb_line_window_sequencer.sv
// Randomized bench for line_window_sequencer; expected windows come from the
// pixel index k of each accepted pixel (x = k % W, y = k / W).
module tb_line_window_sequencer;
  logic       clk = 0;
  logic       reset_n = 0;
  logic       cfg_valid = 0;
  logic [7:0] cfg_width = 0, cfg_height = 0;
  logic       cfg_ready, cfg_error;
  logic       abort = 0, in_valid = 0;
  logic       in_ready, sr_reset, sr_in_valid, win_valid, frame_done;
  logic [15:0] sr_tap_spacing;
  logic [7:0] win_x, win_y;

  int checks = 0;
  int failures = 0;

  line_window_sequencer dut (
    .clk(clk), .reset_n(reset_n), .cfg_valid(cfg_valid), .cfg_width(cfg_width),
    .cfg_height(cfg_height), .cfg_ready(cfg_ready), .cfg_error(cfg_error),
    .abort(abort), .in_valid(in_valid), .in_ready(in_ready), .sr_reset(sr_reset),
    .sr_tap_spacing(sr_tap_spacing), .sr_in_valid(sr_in_valid), .win_valid(win_valid),
    .win_x(win_x), .win_y(win_y), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Configures and streams one frame; mode 0 continuous, 1 every third cycle idle,
  // 2 random bubbles plus stray cfg_valid. abort_k / rst_k cut the frame at pixel k.
  task automatic drive_frame(input int w, input int h, input int mode, input int abort_k,
                             input int rst_k, output int wins, output int first_win);
    int k, cyc;
    bit exp_win;
    k = 0; cyc = 0; wins = 0; first_win = -1;
    cfg_width = 8'(w); cfg_height = 8'(h); cfg_valid = 1;
    @(negedge clk);
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL cfg_ready_idle got=%0d exp=1", cfg_ready); end
    @(posedge clk); #1 cfg_valid = 0;
    @(negedge clk);
    checks++;
    if (sr_reset !== 1'b1 || sr_tap_spacing !== 16'(w) || in_ready !== 1'b0) begin
      failures++; $display("FAIL load sr_reset=%0d spacing=%0d in_ready=%0d exp 1/%0d/0", sr_reset, sr_tap_spacing, in_ready, w);
    end
    @(posedge clk); #1;
    while (k < w * h && cyc < 4000) begin
      in_valid = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 != 2) : ($urandom_range(0, 3) != 0);
      if (mode == 2) begin cfg_valid = $urandom_range(0, 1); cfg_width = 0; end
      if (k == abort_k) begin abort = 1; in_valid = 1; end
      if (k == rst_k) begin
        reset_n = 0; in_valid = 0; cfg_valid = 0;
        @(negedge clk);
        checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL rst_mid_ready got=%0d exp=0", cfg_ready); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({cfg_error, sr_reset, sr_in_valid, win_valid, frame_done, in_ready, cfg_ready} !== 7'b0 || sr_tap_spacing !== 16'd0) begin
          failures++; $display("FAIL rst_mid_outputs got=%b spacing=%0d exp=0", {cfg_error, sr_reset, sr_in_valid, win_valid, frame_done, in_ready, cfg_ready}, sr_tap_spacing);
        end
        @(posedge clk); #1 reset_n = 1;
        @(negedge clk);
        checks++; if (cfg_ready !== 1'b1 || frame_done !== 1'b0) begin failures++; $display("FAIL rst_mid_release ready=%0d done=%0d exp 1/0", cfg_ready, frame_done); end
        @(posedge clk); #1;
        return;
      end
      @(negedge clk);
      exp_win = in_valid && (k / w >= 3);
      checks++;
      if (in_ready !== 1'b1 || sr_in_valid !== in_valid || win_valid !== exp_win || sr_reset !== 1'b0 || frame_done !== 1'b0 || cfg_error !== 1'b0) begin
        failures++; $display("FAIL run_ctl k=%0d rdy=%0d sr_iv=%0d win=%0d srr=%0d done=%0d err=%0d exp 1/%0d/%0d/0/0/0",
                             k, in_ready, sr_in_valid, win_valid, sr_reset, frame_done, cfg_error, in_valid, exp_win);
      end
      if (exp_win) begin
        wins++;
        if (first_win < 0) first_win = k;
        checks++;
        if (win_x !== 8'(k % w) || win_y !== 8'(k / w - 3)) begin
          failures++; $display("FAIL win_coord k=%0d got=(%0d,%0d) exp=(%0d,%0d)", k, win_x, win_y, k % w, k / w - 3);
        end
      end
      @(posedge clk); #1;
      if (in_valid) k++;
      cyc++;
      if (abort) begin
        abort = 0; in_valid = 0; cfg_valid = 0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0 || frame_done !== 1'b0) begin failures++; $display("FAIL abort_stop rdy=%0d done=%0d exp 0/0", in_ready, frame_done); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (cfg_ready !== 1'b1 || frame_done !== 1'b0) begin failures++; $display("FAIL abort_idle ready=%0d done=%0d exp 1/0", cfg_ready, frame_done); end
        @(posedge clk); #1;
        return;
      end
    end
    in_valid = 0; cfg_valid = 0;
    if (cyc >= 4000) begin checks++; failures++; $display("FAIL frame_timeout got=%0d pixels exp=%0d", k, w * h); end
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b1 || in_ready !== 1'b0 || cfg_error !== 1'b0) begin
      failures++; $display("FAIL frame_done done=%0d rdy=%0d err=%0d exp 1/0/0", frame_done, in_ready, cfg_error);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (cfg_ready !== 1'b1 || frame_done !== 1'b0) begin failures++; $display("FAIL post_frame ready=%0d done=%0d exp 1/0", cfg_ready, frame_done); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if ({cfg_ready, cfg_error, sr_reset, sr_in_valid, win_valid, frame_done, in_ready} !== 7'b0 || sr_tap_spacing !== 16'd0) begin
      failures++; $display("FAIL reset_state got=%b spacing=%0d exp=0", {cfg_ready, cfg_error, sr_reset, sr_in_valid, win_valid, frame_done, in_ready}, sr_tap_spacing);
    end
    @(posedge clk); #1 reset_n = 1;
    @(negedge clk);
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL reset_release got=%0d exp=1", cfg_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int wins, first;
    drive_frame(6, 5, 0, -1, -1, wins, first);
    checks++; if (wins != 12 || first != 18) begin failures++; $display("FAIL basic_windows got=%0d@%0d exp=12@18", wins, first); end
  endtask

  task automatic test_bubbles();
    int wins, first;
    drive_frame(6, 5, 1, -1, -1, wins, first);
    checks++; if (wins != 12 || first != 18) begin failures++; $display("FAIL bubble_windows got=%0d@%0d exp=12@18", wins, first); end
  endtask

  task automatic test_back_to_back();
    int wins, first;
    drive_frame(6, 5, 0, -1, -1, wins, first);
    checks++; if (wins != 12) begin failures++; $display("FAIL b2b_first got=%0d exp=12", wins); end
    drive_frame(15, 4, 0, -1, -1, wins, first);
    checks++; if (wins != 15 || first != 45) begin failures++; $display("FAIL b2b_second got=%0d@%0d exp=15@45", wins, first); end
  endtask

  task automatic test_illegal();
    int ws[3] = '{0, 17, 6};
    int hs[3] = '{5, 5, 3};
    logic [15:0] prev;
    prev = sr_tap_spacing;
    for (int i = 0; i < 3; i++) begin
      cfg_valid = 1; cfg_width = 8'(ws[i]); cfg_height = 8'(hs[i]);
      @(posedge clk); #1 cfg_valid = 0;
      @(negedge clk);
      checks++;
      if (cfg_error !== 1'b1 || sr_reset !== 1'b0 || cfg_ready !== 1'b1 || sr_tap_spacing !== prev) begin
        failures++; $display("FAIL illegal_%0d err=%0d srr=%0d rdy=%0d spacing=%0d exp 1/0/1/%0d", i, cfg_error, sr_reset, cfg_ready, sr_tap_spacing, prev);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (cfg_error !== 1'b0 || sr_reset !== 1'b0) begin failures++; $display("FAIL illegal_pulse_%0d err=%0d srr=%0d exp 0/0", i, cfg_error, sr_reset); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_abort();
    int wins, first;
    drive_frame(6, 5, 0, 16, -1, wins, first);
    checks++; if (wins != 0) begin failures++; $display("FAIL abort_windows got=%0d exp=0", wins); end
  endtask

  task automatic test_reset_mid();
    int wins, first;
    drive_frame(6, 5, 0, -1, 26, wins, first);
    drive_frame(6, 5, 0, -1, -1, wins, first);
    checks++; if (wins != 12 || first != 18) begin failures++; $display("FAIL rst_refresh got=%0d@%0d exp=12@18", wins, first); end
  endtask

  task automatic test_random();
    int wins, first, w, h;
    for (int i = 0; i < 6; i++) begin
      w = $urandom_range(1, 16);
      h = $urandom_range(4, 7);
      drive_frame(w, h, 2, -1, -1, wins, first);
      checks++;
      if (wins != (h - 3) * w || first != 3 * w) begin
        failures++; $display("FAIL random_%0dx%0d got=%0d@%0d exp=%0d@%0d", w, h, wins, first, (h - 3) * w, 3 * w);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bubbles();
    test_back_to_back();
    test_illegal();
    test_abort();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/line_window_sequencer.md
# line_window_sequencer

Control block that sequences the multitap shift register through one raster frame. It accepts a frame configuration (width, height) and pulses the shift register's reset with the new tap spacing. It then gates the pixel stream into the register and tracks raster coordinates. It flags the cycles on which the register taps plus the live pixel form a complete vertical column of NUM_TAPS+1 pixels, and signals frame completion. It sits between the pixel source and the windowing datapath of the image pipeline.

## Interface
Parameters:
- COORD_BITS, 8, width of the x/y coordinates and of cfg_width/cfg_height
- NUM_TAPS, 3, number of taps on the driven shift register
- MAX_TAP_SPACING, 16, largest legal row width (shift register depth per tap)

Ports:
- clk  in  1  sole clock; everything is rising-edge.
- reset_n  in  1  synchronous, active-low reset.
- cfg_valid  in  1  configuration request.
- cfg_width  in  COORD_BITS  pixels per row.
- cfg_height  in  COORD_BITS  rows per frame.
- cfg_ready  out  1  block can accept a configuration.
- cfg_error  out  1  one-cycle pulse when a configuration is rejected.
- abort  in  1  cancel the current frame.
- in_valid  in  1  pixel present from source.
- in_ready  out  1  block accepts a pixel this cycle.
- sr_reset  out  1  active-high reset to the shift register.
- sr_tap_spacing  out  16  tap spacing to the shift register, zero-extended width.
- sr_in_valid  out  1  shift enable to the shift register.
- win_valid  out  1  taps plus live pixel form a full column this cycle.
- win_x  out  COORD_BITS  column x.
- win_y  out  COORD_BITS  y of the column's top (oldest) row.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame.

## Operation
- The state machine has four states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - cfg_ready=1 (gated by reset_n); in_ready=0.
  - On cfg_valid, the configuration is checked. It is legal if 1 <= cfg_width <= MAX_TAP_SPACING and cfg_height >= NUM_TAPS+1.
  - Legal: latch width and height into width_reg and height_reg, clear x and y, go to LOAD.
  - Illegal: cfg_error=1 on the next cycle, stay in IDLE, width_reg unchanged.
- LOAD (one cycle): sr_reset=1, in_ready=0, cfg_ready=0. Go to RUN.
- RUN:
  - in_ready=1, cfg_ready=0.
  - A pixel is accepted when in_valid && in_ready. Then sr_in_valid=1, combinationally equal to in_valid.
  - On acceptance, x advances. If x==width_reg-1, x wraps to 0 and y increments.
  - win_valid = accepted && (y >= NUM_TAPS); win_x = x; win_y = y - NUM_TAPS. All three are combinational from the current x and y.
  - Acceptance at x==width_reg-1 and y==height_reg-1 goes to DONE.
- DONE (one cycle): frame_done=1, in_ready=0. Go to IDLE.
- abort in RUN (or in LOAD) goes to IDLE next cycle.
  - No frame_done pulse.
  - If in RUN, a pixel presented in the abort cycle is still accepted.
  - abort has no effect in IDLE or DONE.
- sr_tap_spacing is always {0, width_reg}. It is registered and changes only on a legal configuration.
- Arithmetic is unsigned with COORD_BITS counters. Legal configurations guarantee no overflow.

## Timing
- Reset (reset_n=0 at an edge):
  - state=IDLE; x, y, width_reg, height_reg = 0.
  - Outputs after that edge: cfg_error, sr_reset, sr_in_valid, win_valid, frame_done, in_ready = 0; sr_tap_spacing = 0.
  - cfg_ready=0 while reset_n=0 and 1 after release.
  - Reset mid-frame drops the frame immediately, with no frame_done.
- Configuration accepted at edge T: sr_reset is high in cycle T+1. in_ready is first high in cycle T+2.
- Pixel latency through the block is zero (combinational pass-through to sr_in_valid). Bubbles in in_valid stall x and y.
- The last pixel is accepted in cycle N. frame_done is high in cycle N+1, and cfg_ready is high again in cycle N+2.
- cfg_valid outside IDLE is ignored and produces no cfg_error.

## Test plan
- Width 6, height 5, continuous pixels 0..29:
  - sr_reset is high exactly one cycle, with sr_tap_spacing=6.
  - win_valid is first high on pixel 18 (win_x=0, win_y=0) and is high for 12 pixels total.
  - frame_done is high the cycle after pixel 29.
- Same frame with in_valid deasserted every third cycle: identical win_valid count and coordinates, and frame_done after the 30th accepted pixel.
- Back-to-back frames: width 6 and height 5, then width 15 and height 4.
  - The second LOAD shows sr_tap_spacing=15.
  - Second frame: first win_valid on pixel 45 with win_y=0; 15 windows total.
- Illegal configurations: width 0, width 17, and height 3 with NUM_TAPS=3 each give a cfg_error pulse, no sr_reset, cfg_ready staying 1, and sr_tap_spacing unchanged.
- abort at y=2, x=4 of a 6x5 frame: in_ready drops the next cycle, no frame_done, and cfg_ready=1 after that.
- reset_n low at y=4, x=2 of a 6x5 frame: all outputs clear per the reset list. After release, a new 6x5 frame behaves exactly as in the first scenario.
